pipeline_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline. Drives the IF/ID register's stall/flush pins and the
//  ID/EX, EX/MEM, MEM/WB stall/bubble controls.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 17 +
 rtl/pipeline_hazard_ctrl_if.sv | 38 +++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// the hard-wired zero register number and a register-match helper.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a source operand is actually read and names the given register.
  function automatic logic reg_match(input logic use_f, input logic [4:0] src, input logic [4:0] dst);
    return use_f & (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-side hazard inputs and stall/flush control outputs.
// master: the pipeline (drives hazard inputs); slave: the hazard controller.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  rs_ID;
  logic [4:0]  rt_ID;
  logic        use_rs_ID;
  logic        use_rt_ID;
  logic [4:0]  rt_EX;
  logic        mem_read_EX;
  logic        jump_ID;
  logic        br_taken_EX;
  logic        mem_req_MEM;
  logic        mem_ready_MEM;
  logic        stall_IF;
  logic        stall_ID;
  logic        flush_ID;
  logic        stall_EX;
  logic        flush_EX;
  logic        stall_MEM;
  logic        flush_WB;
  logic        mem_err;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;

  modport master (
    output rs_ID, rt_ID, use_rs_ID, use_rt_ID, rt_EX, mem_read_EX, jump_ID,
           br_taken_EX, mem_req_MEM, mem_ready_MEM,
    input  stall_IF, stall_ID, flush_ID, stall_EX, flush_EX, stall_MEM, flush_WB,
           mem_err, perf_stall, perf_flush
  );

  modport slave (
    input  rs_ID, rt_ID, use_rs_ID, use_rt_ID, rt_EX, mem_read_EX, jump_ID,
           br_taken_EX, mem_req_MEM, mem_ready_MEM,
    output stall_IF, stall_ID, flush_ID, stall_EX, flush_EX, stall_MEM, flush_WB,
           mem_err, perf_stall, perf_flush
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Purely combinational load-use comparator: the load in EX writes a register
// that the instruction in ID reads. Register 0 never creates a dependency.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_ID,
  input  logic [4:0] rt_ID,
  input  logic       use_rs_ID,
  input  logic       use_rt_ID,
  input  logic [4:0] rt_EX,
  input  logic       mem_read_EX,
  output logic       load_use
);

  // Dependency compare between the EX load destination and the ID sources.
  always_comb begin
    load_use = 1'b0;
    if (mem_read_EX && (rt_EX != REG_ZERO)) begin
      load_use = reg_match(use_rs_ID, rs_ID, rt_EX) | reg_match(use_rt_ID, rt_ID, rt_EX);
    end else begin
      load_use = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Priority: memory wait > taken branch > load-use > jump.
// Optional feature macro: PIPE_PERF_CNT_EN enables the stall/flush perf counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 8
) (
  input logic               clk,
  input logic               rst,
  pipeline_hazard_ctrl_if.slave hif
);

  // wait_cnt holds the number of memory-wait cycles already completed before
  // the current one, so the MEM_TIMEOUT-th wait cycle is the one where the
  // count equals MEM_TIMEOUT-1; this lets CNT_W bits cover MEM_TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic             mem_wait_s;
  logic             load_use_s;
  logic             timeout_hit_s;
  logic [6:0]       ctrl_s;  // {stall_IF, stall_ID, flush_ID, stall_EX, flush_EX, stall_MEM, flush_WB}

  load_use_detect u_load_use (
    .rs_ID       (hif.rs_ID),
    .rt_ID       (hif.rt_ID),
    .use_rs_ID   (hif.use_rs_ID),
    .use_rt_ID   (hif.use_rt_ID),
    .rt_EX       (hif.rt_EX),
    .mem_read_EX (hif.mem_read_EX),
    .load_use    (load_use_s)
  );

  assign mem_wait_s    = hif.mem_req_MEM & ~hif.mem_ready_MEM;
  assign timeout_hit_s = mem_wait_s & (wait_cnt_q == CNT_TOP);

  // Priority mux for the stall/flush controls; everything drops while in reset.
  // A jump coinciding with load-use gets no flush here: IF/ID is held, so it is
  // seen again (and acted on) in the following cycle.
  always_comb begin
    ctrl_s = 7'b000_0000;
    if (rst) begin
      ctrl_s = 7'b000_0000;
    end else if (mem_wait_s) begin
      ctrl_s = 7'b110_1011;
    end else if (hif.br_taken_EX) begin
      ctrl_s = 7'b001_0100;
    end else if (load_use_s) begin
      ctrl_s = 7'b110_0100;
    end else if (hif.jump_ID) begin
      ctrl_s = 7'b001_0000;
    end else begin
      ctrl_s = 7'b000_0000;
    end
  end

  assign {hif.stall_IF, hif.stall_ID, hif.flush_ID, hif.stall_EX,
          hif.flush_EX, hif.stall_MEM, hif.flush_WB} = ctrl_s;
  assign hif.mem_err = ~rst & (mem_err_q | timeout_hit_s);

  // Next-state, wait counter and sticky timeout flag.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q | timeout_hit_s;
    case (state_q)
      RUN: begin
        if (mem_wait_s) begin
          state_d    = WAIT;
          wait_cnt_d = CNT_W'(1);
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        if (mem_wait_s) begin
          state_d    = WAIT;
          wait_cnt_d = (wait_cnt_q == CNT_TOP) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // State, counter and error flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Count cycles with any stall and cycles with an IF/ID or ID/EX flush.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (ctrl_s[6] | ctrl_s[5] | ctrl_s[3] | ctrl_s[1]) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
    if (ctrl_s[4] | ctrl_s[2]) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end else begin
      perf_flush_d = perf_flush_q;
    end
  end

  // Performance counter registers; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign hif.perf_stall = perf_stall_q;
  assign hif.perf_flush = perf_flush_q;
`else
  assign hif.perf_stall = 32'd0;
  assign hif.perf_flush = 32'd0;
`endif

endmodule
